// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the CPU top level:
// FSM state encoding, memory word width and the default word-address width.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int ADDR_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_CKSUM = 3'd4
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bus of the loader. The master modport is
// the loader itself; cksum_err exists only when IMEM_LOADER_CKSUM_EN is defined.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::ADDR_W_DEFAULT
);

    logic                              start;
    logic [ADDR_W:0]                   word_count;
    logic [imem_loader_pkg::BYTE_W-1:0] byte_in;
    logic                              byte_valid;
    logic                              byte_ready;
    logic                              mem_we;
    logic [ADDR_W-1:0]                 mem_addr;
    logic [imem_loader_pkg::WORD_W-1:0] mem_wdata;
    logic                              busy;
    logic                              done;
    logic                              cpu_hold;
`ifdef IMEM_LOADER_CKSUM_EN
    logic                              cksum_err;
`endif

    modport master (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold
`ifdef IMEM_LOADER_CKSUM_EN
        , output cksum_err
`endif
    );

    modport slave (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold
`ifdef IMEM_LOADER_CKSUM_EN
        , input cksum_err
`endif
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: shifts bytes into a 32-bit word (first byte lands in
// [31:24]) and flags the transfer that completes a 4-byte group.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;

    // NOTE: every combinational output gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = shift_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into words written from address 0
// and holds the CPU meanwhile. IMEM_LOADER_CKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ready;
    logic                xfer;
    logic                pack_clear;
    logic                pack_shift;
    logic                word_ready;
    logic                last_word;
    logic [WORD_W-1:0]   packed_word;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [BYTE_W-1:0]   xor_q, xor_d;
    logic                err_q, err_d;
`endif

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pack_clear),
        .shift_i      (pack_shift),
        .byte_i       (bus.byte_in),
        .word_o       (packed_word),
        .word_ready_o (word_ready)
    );

`ifdef IMEM_LOADER_CKSUM_EN
    assign ready = (state_q == ST_RECV) || (state_q == ST_CKSUM);
`else
    assign ready = (state_q == ST_RECV);
`endif
    assign xfer       = bus.byte_valid && ready;
    assign pack_shift = xfer && (state_q == ST_RECV);
    assign last_word  = ({1'b0, addr_q} == (n_q - (ADDR_W+1)'(1)));

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        addr_d     = addr_q;
        pack_clear = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
        xor_d      = xor_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    n_d        = (bus.word_count > MAX_WORDS) ? MAX_WORDS : bus.word_count;
                    addr_d     = '0;
                    pack_clear = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
                    xor_d      = '0;
                    err_d      = 1'b0;
                    state_d    = (bus.word_count == '0) ? ST_CKSUM : ST_RECV;
`else
                    state_d    = (bus.word_count == '0) ? ST_DONE : ST_RECV;
`endif
                end
            end
            ST_RECV: begin
`ifdef IMEM_LOADER_CKSUM_EN
                if (xfer) xor_d = xor_q ^ bus.byte_in;
`endif
                if (word_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    state_d = ST_CKSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_RECV;
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                // The checksum byte covers every data byte accepted since start.
                if (xfer) begin
                    err_d   = (bus.byte_in != xor_q);
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            addr_q  <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q   <= xor_d;
            err_q   <= err_d;
`endif
        end
    end

    // All outputs decode directly from registered state, so they are glitch-free.
    assign bus.byte_ready = ready;
    assign bus.mem_we     = (state_q == ST_WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = packed_word;
    assign bus.done       = (state_q == ST_DONE);
`ifdef IMEM_LOADER_CKSUM_EN
    assign bus.busy       = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CKSUM);
    assign bus.cksum_err  = err_q;
`else
    assign bus.busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
`endif
    assign bus.cpu_hold   = bus.busy;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized byte streams and valid gaps, with expected writes
// derived from the accepted byte list (4 bytes per big-endian word, addresses 0..N-1).
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W    = ADDR_W_DEFAULT;
    localparam int MAX_WORDS = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int unsigned wcyc;
        logic        ready;
    } wr_t;

    wr_t         wr_q[$];
    logic [7:0]  byte_q[$];
    int unsigned xcyc_q[$];
    logic [7:0]  src_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_t w;
            w.addr  = 32'(bus.mem_addr);
            w.data  = bus.mem_wdata;
            w.wcyc  = cyc;
            w.ready = bus.byte_ready;
            wr_q.push_back(w);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] next_byte();
        if (src_q.size() > 0) return src_q.pop_front();
        return 8'($urandom);
    endfunction

    task automatic do_start(input int wc);
        wr_q.delete();
        byte_q.delete();
        xcyc_q.delete();
        bus.start      = 1'b1;
        bus.word_count = (ADDR_W+1)'(wc);
        @(negedge clk);
        bus.start = 1'b0;
        if (wc != 0) begin
            check("start_done_clr", bus.done, 0);
            check("start_busy", bus.busy, 1);
        end
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid.
    task automatic send_stream(input int nbytes, input int mode, input bit poke);
        int sent   = 0;
        int k      = 0;
        int budget = nbytes * 12 + 64;
        bit xfer;
        bus.byte_in = next_byte();
        while (sent < nbytes && budget > 0) begin
            case (mode)
                0:       bus.byte_valid = 1'b1;
                1:       bus.byte_valid = (k % 2 == 0);
                default: bus.byte_valid = 1'($urandom_range(0, 1));
            endcase
            bus.start = 1'b0;
            if (poke && sent >= nbytes / 2 && bus.busy === 1'b1) begin
                bus.start      = 1'b1;
                bus.word_count = '0;
                poke           = 1'b0;
            end
            xfer = (bus.byte_valid === 1'b1) && (bus.byte_ready === 1'b1);
            if (xfer) begin
                byte_q.push_back(bus.byte_in);
                xcyc_q.push_back(cyc + 1);
            end
            @(negedge clk);
            k++;
            budget--;
            if (xfer) begin
                sent++;
                if (sent < nbytes) bus.byte_in = next_byte();
            end
        end
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        check("stream_bytes", sent, nbytes);
    endtask

    task automatic wait_done(input string tag);
        int budget = 64;
        while (bus.done !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_hold"}, bus.cpu_hold, 0);
        check({tag, "_ready"}, bus.byte_ready, 0);
        check({tag, "_we"}, bus.mem_we, 0);
    endtask

`ifdef IMEM_LOADER_CKSUM_EN
    function automatic logic [7:0] xor_of_bytes();
        logic [7:0] x = '0;
        foreach (byte_q[i]) x ^= byte_q[i];
        return x;
    endfunction

    task automatic send_cksum(input string tag, input logic [7:0] b);
        logic [7:0] x      = xor_of_bytes();
        int         budget = 64;
        bit         taken  = 1'b0;
        while (bus.byte_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        // A start while waiting for the checksum byte must be ignored.
        bus.start      = 1'b1;
        bus.word_count = '0;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!taken && budget > 0) begin
            taken = (bus.byte_ready === 1'b1);
            @(negedge clk);
            budget--;
        end
        bus.byte_valid = 1'b0;
        check({tag, "_ck_taken"}, taken, 1);
        wait_done(tag);
        check({tag, "_ck_err"}, bus.cksum_err, (b != x));
    endtask
`endif

    task automatic finish_load(input string tag);
`ifdef IMEM_LOADER_CKSUM_EN
        send_cksum(tag, xor_of_bytes());
`else
        wait_done(tag);
`endif
    endtask

    task automatic verify_writes(input string tag, input int exp_words);
        logic [31:0] w;
        check({tag, "_nwrites"}, wr_q.size(), exp_words);
        for (int k = 0; k < exp_words && k < wr_q.size() && 4 * k + 3 < byte_q.size(); k++) begin
            w = {byte_q[4*k], byte_q[4*k+1], byte_q[4*k+2], byte_q[4*k+3]};
            check($sformatf("%s_addr%0d", tag, k), wr_q[k].addr, k);
            check($sformatf("%s_data%0d", tag, k), wr_q[k].data, w);
            check($sformatf("%s_lat%0d", tag, k), wr_q[k].wcyc, xcyc_q[4*k+3]);
            check($sformatf("%s_rdy%0d", tag, k), wr_q[k].ready, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;

        // Reset with a concurrent start: reset must win.
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.word_count = (ADDR_W+1)'(2);
        bus.byte_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.byte_ready, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hold", bus.cpu_hold, 0);
`ifdef IMEM_LOADER_CKSUM_EN
        check("rst_ckerr", bus.cksum_err, 0);
`endif
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        rst            = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("idle_ready", bus.byte_ready, 0);

        // Zero-length load.
        do_start(0);
`ifdef IMEM_LOADER_CKSUM_EN
        check("zero_busy", bus.busy, 1);
        finish_load("zero");
`else
        check("zero_done", bus.done, 1);
        check("zero_busy", bus.busy, 0);
`endif
        repeat (3) @(negedge clk);
        check("zero_writes", wr_q.size(), 0);

        // Basic two-word load, valid held high.
        src_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
        do_start(2);
        send_stream(8, 0, 1'b0);
        finish_load("basic");
        verify_writes("basic", 2);
        if (wr_q.size() == 2) begin
            check("basic_golden0", wr_q[0].data, 32'h8C010004);
            check("basic_golden1", wr_q[1].data, 32'hAC020008);
        end

        // Same load with valid toggling and a start pulse while busy.
        src_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
        do_start(2);
        send_stream(8, 1, 1'b1);
        finish_load("gaps");
        verify_writes("gaps", 2);
        if (wr_q.size() == 2) begin
            check("gaps_golden0", wr_q[0].data, 32'h8C010004);
            check("gaps_golden1", wr_q[1].data, 32'hAC020008);
        end

        // Random loads with random gaps.
        for (int i = 0; i < 6; i++) begin
            int n;
            n = $urandom_range(1, 8);
            do_start(n);
            send_stream(4 * n, 2, 1'($urandom_range(0, 1)));
            finish_load("rand");
            verify_writes($sformatf("rand%0d", i), n);
        end

        // Oversized word_count is clamped to the memory size.
        do_start(MAX_WORDS + 5);
        send_stream(4 * MAX_WORDS, 0, 1'b0);
        finish_load("clamp");
        verify_writes("clamp", MAX_WORDS);
        if (wr_q.size() > 0) check("clamp_last_addr", wr_q[wr_q.size()-1].addr, MAX_WORDS - 1);

        // Reset after 6 bytes of a 3-word load.
        do_start(3);
        send_stream(6, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        verify_writes("rstmid", 1);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_done", bus.done, 0);
        check("rstmid_ready", bus.byte_ready, 0);
        check("rstmid_addr", bus.mem_addr, 0);
        do_start(1);
        send_stream(4, 0, 1'b0);
        finish_load("after_rst");
        verify_writes("after_rst", 1);

`ifdef IMEM_LOADER_CKSUM_EN
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_start(1);
        send_stream(4, 0, 1'b0);
        send_cksum("ck_good", 8'h04);
        check("ck_good_err", bus.cksum_err, 0);
        verify_writes("ck_good", 1);

        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_start(1);
        send_stream(4, 0, 1'b0);
        send_cksum("ck_bad", 8'hFF);
        check("ck_bad_err", bus.cksum_err, 1);
        verify_writes("ck_bad", 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
